// File: rtl/char_demux_buf_if.sv
// Bundle of the upstream character stream and the two downstream channel
// streams of char_demux_buf, with per-channel accepted-character counts.
interface char_demux_buf_if #(
  parameter int CNT_W = 8
);
  // Handshake rule for every stream here: a transfer happens on a rising clock
  // edge where valid and ready are both high. A producer holds valid and its
  // data steady until that edge, and ready never depends on the same-cycle valid.
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_sel;
  logic             in_ready;
  logic             a_valid;
  logic [7:0]       a_data;
  logic             a_ready;
  logic             b_valid;
  logic [7:0]       b_data;
  logic             b_ready;
  logic [CNT_W-1:0] a_count;
  logic [CNT_W-1:0] b_count;

  modport master (
    output in_valid, in_data, in_sel, a_ready, b_ready,
    input  in_ready, a_valid, a_data, b_valid, b_data, a_count, b_count
  );

  modport slave (
    input  in_valid, in_data, in_sel, a_ready, b_ready,
    output in_ready, a_valid, a_data, b_valid, b_data, a_count, b_count
  );
endinterface

// File: rtl/char_demux_buf.sv
// Steers each upstream character into channel A or B by in_sel. Each channel
// is a DEPTH-entry circular FIFO that drains to its own consumer.
module char_demux_buf #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  char_demux_buf_if.slave  bus,
  output logic [1:0]       a_state,
  output logic [1:0]       b_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  typedef enum logic [1:0] {
    CH_EMPTY   = 2'd0,
    CH_PARTIAL = 2'd1,
    CH_FULL    = 2'd2
  } ch_state_e;

  // Index 0 is channel A, index 1 is channel B.
  logic [7:0]       mem    [2][DEPTH];
  logic [PTR_W-1:0] wr_ptr [2];
  logic [PTR_W-1:0] rd_ptr [2];
  logic [OCC_W-1:0] occ    [2];
  logic [CNT_W-1:0] cnt    [2];
  logic             full   [2];
  logic             push   [2];
  logic             pop    [2];
  logic             cons_rdy [2];
  ch_state_e        ch_state [2];
  logic             sel_ready;

  always_comb begin
    cons_rdy[0] = bus.a_ready;
    cons_rdy[1] = bus.b_ready;
    for (int c = 0; c < 2; c++) begin
      full[c] = (occ[c] == OCC_FULL);
      pop[c]  = (occ[c] != '0) && cons_rdy[c];
    end
    // Acceptance looks only at registered occupancy, so a pop on the same
    // edge never frees room for a push into a full channel.
    sel_ready = rst_n && (bus.in_sel ? !full[1] : !full[0]);
    push[0]   = bus.in_valid && sel_ready && !bus.in_sel;
    push[1]   = bus.in_valid && sel_ready &&  bus.in_sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        occ[c]    <= '0;
        cnt[c]    <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (push[c]) begin
          wr_ptr[c] <= wr_ptr[c] + PTR_W'(1);
          cnt[c]    <= cnt[c] + CNT_W'(1);
        end
        if (pop[c]) begin
          rd_ptr[c] <= rd_ptr[c] + PTR_W'(1);
        end
        if (push[c] && !pop[c]) begin
          occ[c] <= occ[c] + OCC_W'(1);
        end else if (pop[c] && !push[c]) begin
          occ[c] <= occ[c] - OCC_W'(1);
        end
      end
    end
  end

  // Storage is deliberately not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (push[c]) begin
        mem[c][wr_ptr[c]] <= bus.in_data;
      end
    end
  end

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      ch_state[c] = CH_PARTIAL;
      if (occ[c] == '0) begin
        ch_state[c] = CH_EMPTY;
      end else if (full[c]) begin
        ch_state[c] = CH_FULL;
      end
    end
  end

  assign a_state      = ch_state[0];
  assign b_state      = ch_state[1];

  assign bus.in_ready = sel_ready;
  assign bus.a_valid  = (occ[0] != '0);
  assign bus.b_valid  = (occ[1] != '0);
  assign bus.a_data   = mem[0][rd_ptr[0]];
  assign bus.b_data   = mem[1][rd_ptr[1]];
  assign bus.a_count  = cnt[0];
  assign bus.b_count  = cnt[1];

endmodule
